// File: rtl/lstm_delta.sv
// Shared fixed-point LSTM backprop datapath: two multipliers and one add/sub unit, all muxed by
// per-cycle selects. Define DELTA_SAT_EN to clamp MUL/AS results on overflow instead of wrapping.
module lstm_delta #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              sel_in1,
  input  logic [1:0]              sel_in2,
  input  logic [1:0]              sel_x1_1,
  input  logic                    sel_x1_2,
  input  logic                    sel_in3,
  input  logic [1:0]              sel_in4,
  input  logic [1:0]              sel_x2_2,
  input  logic                    sel_as_1,
  input  logic [1:0]              sel_as_2,
  input  logic                    sel_addsub,
  input  logic [1:0]              sel_temp,
  input  logic [2:0]              sel_in5,
  input  logic signed [WIDTH-1:0] at,
  input  logic signed [WIDTH-1:0] it,
  input  logic signed [WIDTH-1:0] ft,
  input  logic signed [WIDTH-1:0] ot,
  input  logic signed [WIDTH-1:0] h,
  input  logic signed [WIDTH-1:0] t,
  input  logic signed [WIDTH-1:0] state,
  input  logic signed [WIDTH-1:0] d_state,
  input  logic signed [WIDTH-1:0] d_out,
  output logic signed [WIDTH-1:0] o_dgate,
  output logic signed [WIDTH-1:0] o_d_state
);

  localparam logic signed [WIDTH-1:0] ONE  = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  // d_out is reserved for a future output-delta path.
  logic unused_d_out;
  assign unused_d_out = ^d_out;

  function automatic logic signed [WIDTH-1:0] mul_fx(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] ax;
    logic signed [2*WIDTH-1:0] bx;
    logic signed [2*WIDTH-1:0] prod;
`ifdef DELTA_SAT_EN
    logic signed [2*WIDTH-1:0] sh;
`endif
    ax   = {{WIDTH{a[WIDTH-1]}}, a};
    bx   = {{WIDTH{b[WIDTH-1]}}, b};
    prod = ax * bx;
`ifdef DELTA_SAT_EN
    sh = prod >>> FRAC;
    // In range only if every discarded high bit repeats the kept sign bit.
    if (!((&sh[2*WIDTH-1:WIDTH-1]) || !(|sh[2*WIDTH-1:WIDTH-1])))
      return sh[2*WIDTH-1] ? MINV : MAXV;
    return sh[WIDTH-1:0];
`else
    return WIDTH'(prod >>> FRAC);
`endif
  endfunction

  function automatic logic signed [WIDTH-1:0] addsub_fx(input logic signed [WIDTH-1:0] a,
                                                        input logic signed [WIDTH-1:0] b,
                                                        input logic                    sub);
`ifdef DELTA_SAT_EN
    logic signed [WIDTH:0] s;
    if (sub) s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    else     s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1])
      return s[WIDTH] ? MINV : MAXV;
    return s[WIDTH-1:0];
`else
    return sub ? (a - b) : (a + b);
`endif
  endfunction

  logic signed [WIDTH-1:0] r_x1_q, r_x1_d;
  logic signed [WIDTH-1:0] r_x2_q, r_x2_d;
  logic signed [WIDTH-1:0] r_as_q, r_as_d;
  logic signed [WIDTH-1:0] r_temp_q, r_temp_d;
  logic signed [WIDTH-1:0] dgate_q, dgate_d;
  logic signed [WIDTH-1:0] dstate_q, dstate_d;

  logic signed [WIDTH-1:0] in1, in2, in4;
  logic signed [WIDTH-1:0] m1_a, m1_b, m2_a, m2_b, as_a, as_b;

  always_comb begin
    in1 = r_as_q;
    case (sel_in1)
      2'd0: in1 = r_as_q;
      2'd1: in1 = ot;
      2'd2: in1 = t;
      2'd3: in1 = at;
    endcase

    in2 = ONE;
    case (sel_in2)
      2'd0: in2 = ONE;
      2'd1: in2 = it;
      2'd2: in2 = state;
      2'd3: in2 = h;
    endcase

    m1_a = in1;
    case (sel_x1_1)
      2'd0: m1_a = in1;
      2'd1: m1_a = ft;
      2'd2: m1_a = r_temp_q;
      2'd3: m1_a = r_x2_q;
    endcase

    m1_b = sel_x1_2 ? r_temp_q : in2;
    m2_a = sel_in3 ? d_state : r_x1_q;

    in4 = at;
    case (sel_in4)
      2'd0: in4 = at;
      2'd1: in4 = it;
      2'd2: in4 = ot;
      2'd3: in4 = state;
    endcase

    m2_b = in4;
    case (sel_x2_2)
      2'd0: m2_b = in4;
      2'd1: m2_b = r_as_q;
      2'd2: m2_b = r_temp_q;
      2'd3: m2_b = ft;
    endcase

    as_a = sel_as_1 ? ONE : r_x1_q;

    as_b = r_x2_q;
    case (sel_as_2)
      2'd0: as_b = r_x2_q;
      2'd1: as_b = r_temp_q;
      2'd2: as_b = r_x1_q;
      2'd3: as_b = h;
    endcase
  end

  always_comb begin
    r_x1_d = mul_fx(m1_a, m1_b);
    r_x2_d = mul_fx(m2_a, m2_b);
    r_as_d = addsub_fx(as_a, as_b, sel_addsub);

    r_temp_d = r_temp_q;
    case (sel_temp)
      2'd0: r_temp_d = r_temp_q;
      2'd1: r_temp_d = r_as_q;
      2'd2: r_temp_d = r_x2_q;
      2'd3: r_temp_d = r_x1_q;
    endcase

    // Output loads pick from pre-edge unit registers; no same-cycle bypass.
    dgate_d  = dgate_q;
    dstate_d = dstate_q;
    case (sel_in5)
      3'd0: ;
      3'd1: dgate_d  = r_x1_q;
      3'd2: dgate_d  = r_x2_q;
      3'd3: dgate_d  = r_as_q;
      3'd4: dstate_d = r_as_q;
      3'd5: dstate_d = r_x2_q;
      3'd6: dgate_d  = r_temp_q;
      3'd7: dgate_d  = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x1_q   <= '0;
      r_x2_q   <= '0;
      r_as_q   <= '0;
      r_temp_q <= '0;
      dgate_q  <= '0;
      dstate_q <= '0;
    end else begin
      r_x1_q   <= r_x1_d;
      r_x2_q   <= r_x2_d;
      r_as_q   <= r_as_d;
      r_temp_q <= r_temp_d;
      dgate_q  <= dgate_d;
      dstate_q <= dstate_d;
    end
  end

  assign o_dgate   = dgate_q;
  assign o_d_state = dstate_q;

endmodule

// File: tb/tb_lstm_delta.sv
// Directed bench for lstm_delta: table of two-cycle operations plus hand-written chains for
// multi-stage ops, overflow, output hold and asynchronous reset.
module tb_lstm_delta;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel_in1, sel_in2, sel_x1_1, sel_in4, sel_x2_2, sel_as_2, sel_temp;
  logic        sel_x1_2, sel_in3, sel_as_1, sel_addsub;
  logic [2:0]  sel_in5;
  logic [31:0] at, it, ft, ot, h, t, state, d_state, d_out;
  logic [31:0] o_dgate, o_d_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lstm_delta #(.WIDTH(32), .FRAC(24)) dut (
    .clk(clk), .rst(rst),
    .sel_in1(sel_in1), .sel_in2(sel_in2), .sel_x1_1(sel_x1_1), .sel_x1_2(sel_x1_2),
    .sel_in3(sel_in3), .sel_in4(sel_in4), .sel_x2_2(sel_x2_2), .sel_as_1(sel_as_1),
    .sel_as_2(sel_as_2), .sel_addsub(sel_addsub), .sel_temp(sel_temp), .sel_in5(sel_in5),
    .at(at), .it(it), .ft(ft), .ot(ot), .h(h), .t(t), .state(state),
    .d_state(d_state), .d_out(d_out),
    .o_dgate(o_dgate), .o_d_state(o_d_state)
  );

  typedef struct {
    string       name;
    logic [1:0]  s1, s2, x11;
    logic        x12, s3;
    logic [1:0]  s4, x22;
    logic        as1;
    logic [1:0]  as2;
    logic        sub;
    logic [31:0] at, it, ft, ot, h, t, st, ds;
    logic [2:0]  ld;
    logic [31:0] exp_dg, exp_ds;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t blank(input string n);
    vec_t r;
    r.name = n;
    r.s1 = 0; r.s2 = 0; r.x11 = 0; r.x12 = 0; r.s3 = 0; r.s4 = 0; r.x22 = 0;
    r.as1 = 0; r.as2 = 0; r.sub = 0;
    r.at = 0; r.it = 0; r.ft = 0; r.ot = 0; r.h = 0; r.t = 0; r.st = 0; r.ds = 0;
    r.ld = 0; r.exp_dg = 0; r.exp_ds = 0;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sel_in1 = 0; sel_in2 = 0; sel_x1_1 = 0; sel_x1_2 = 0; sel_in3 = 0; sel_in4 = 0;
    sel_x2_2 = 0; sel_as_1 = 0; sel_as_2 = 0; sel_addsub = 0; sel_temp = 0; sel_in5 = 0;
    at = 0; it = 0; ft = 0; ot = 0; h = 0; t = 0; state = 0; d_state = 0; d_out = 0;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    sel_in1 = v.s1; sel_in2 = v.s2; sel_x1_1 = v.x11; sel_x1_2 = v.x12; sel_in3 = v.s3;
    sel_in4 = v.s4; sel_x2_2 = v.x22; sel_as_1 = v.as1; sel_as_2 = v.as2; sel_addsub = v.sub;
    at = v.at; it = v.it; ft = v.ft; ot = v.ot; h = v.h; t = v.t; state = v.st; d_state = v.ds;
    sel_temp = 0; sel_in5 = 0;
    tick();
    sel_in5 = v.ld;
    tick();
    sel_in5 = 0;
    check({v.name, ".dgate"}, o_dgate, v.exp_dg);
    check({v.name, ".dstate"}, o_d_state, v.exp_ds);
  endtask

  initial begin
    // Table: each entry is operand cycle then load cycle; expectations track running outputs.
    vecs[0] = blank("mul1_ft_it");
    vecs[0].x11 = 1; vecs[0].s2 = 1; vecs[0].ft = 32'h0080_0000; vecs[0].it = 32'h0080_0000;
    vecs[0].ld = 1; vecs[0].exp_dg = 32'h0040_0000; vecs[0].exp_ds = 32'h0;

    vecs[1] = blank("one_minus_h");
    vecs[1].as1 = 1; vecs[1].as2 = 3; vecs[1].sub = 1; vecs[1].h = 32'h0040_0000;
    vecs[1].ld = 3; vecs[1].exp_dg = 32'h00C0_0000; vecs[1].exp_ds = 32'h0;

    vecs[2] = blank("dstate_x_ft");
    vecs[2].s3 = 1; vecs[2].x22 = 3; vecs[2].ds = 32'h0200_0000; vecs[2].ft = 32'h0080_0000;
    vecs[2].ld = 5; vecs[2].exp_dg = 32'h00C0_0000; vecs[2].exp_ds = 32'h0100_0000;

    vecs[3] = blank("mul2_ds_ot");
    vecs[3].s3 = 1; vecs[3].s4 = 2; vecs[3].ds = 32'h0080_0000; vecs[3].ot = 32'h00C0_0000;
    vecs[3].ld = 2; vecs[3].exp_dg = 32'h0060_0000; vecs[3].exp_ds = 32'h0100_0000;

    vecs[4] = blank("mul1_neg");
    vecs[4].s1 = 3; vecs[4].s2 = 2; vecs[4].at = 32'hFF80_0000; vecs[4].st = 32'h0080_0000;
    vecs[4].ld = 1; vecs[4].exp_dg = 32'hFFC0_0000; vecs[4].exp_ds = 32'h0100_0000;

    vecs[5] = blank("mul1_trunc_floor");
    vecs[5].s1 = 3; vecs[5].s2 = 1; vecs[5].at = 32'hFFFF_FFFF; vecs[5].it = 32'h0080_0000;
    vecs[5].ld = 1; vecs[5].exp_dg = 32'hFFFF_FFFF; vecs[5].exp_ds = 32'h0100_0000;

    vecs[6] = blank("clear_dgate");
    vecs[6].ld = 7; vecs[6].exp_dg = 32'h0; vecs[6].exp_ds = 32'h0100_0000;

    vecs[7] = blank("as_add_ovf");
    vecs[7].as1 = 1; vecs[7].as2 = 3; vecs[7].h = 32'h7F00_0000; vecs[7].ld = 3;
`ifdef DELTA_SAT_EN
    vecs[7].exp_dg = 32'h7FFF_FFFF;
`else
    vecs[7].exp_dg = 32'h8000_0000;
`endif
    vecs[7].exp_ds = 32'h0100_0000;

    vecs[8] = blank("dstate_from_as");
    vecs[8].as1 = 1; vecs[8].as2 = 3; vecs[8].sub = 1; vecs[8].h = 32'h0040_0000;
    vecs[8].ld = 4; vecs[8].exp_dg = vecs[7].exp_dg; vecs[8].exp_ds = 32'h00C0_0000;

    // Reset held with busy inputs
    idle();
    rst = 1'b0;
    sel_in5 = 3'd1; sel_x1_1 = 1; ft = 32'h0100_0000; h = 32'h0100_0000; sel_as_1 = 1;
    #2;
    check("reset.dgate", o_dgate, 32'h0);
    check("reset.dstate", o_d_state, 32'h0);
    repeat (3) tick();
    check("reset_held.dgate", o_dgate, 32'h0);
    check("reset_held.dstate", o_d_state, 32'h0);
    idle();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) apply(vecs[i]);

    // t - h chain: MUL1 t*ONE, then AS r_x1 - h, then load
    idle();
    sel_in1 = 2; sel_in2 = 0; t = 32'h0140_0000;
    tick();
    sel_as_1 = 0; sel_as_2 = 3; h = 32'h00C0_0000; sel_addsub = 1;
    tick();
    sel_in5 = 3;
    tick();
    check("t_minus_h", o_dgate, 32'h0080_0000);

    // r_temp path: square via r_temp
    idle();
    sel_x1_1 = 1; sel_in2 = 1; ft = 32'h0080_0000; it = 32'h0080_0000;
    tick();
    sel_temp = 3;
    tick();
    sel_temp = 0; sel_in5 = 6; sel_x1_1 = 2; sel_x1_2 = 1;
    tick();
    check("temp_load", o_dgate, 32'h0040_0000);
    sel_in5 = 1;
    tick();
    check("temp_square", o_dgate, 32'h0010_0000);

    // MUL1 positive overflow then hold
    idle();
    sel_in1 = 2; sel_in2 = 3; t = 32'h7F00_0000; h = 32'h0200_0000;
    tick();
    sel_in5 = 1;
    tick();
`ifdef DELTA_SAT_EN
    check("mul_ovf_pos", o_dgate, 32'h7FFF_FFFF);
`else
    check("mul_ovf_pos", o_dgate, 32'hFE00_0000);
`endif
    idle();
    sel_x1_1 = 1; ft = 32'h0080_0000;
    sel_as_1 = 1; sel_in3 = 1; d_state = 32'h0100_0000; sel_x2_2 = 3;
    for (int k = 0; k < 3; k++) begin
      tick();
`ifdef DELTA_SAT_EN
      check("hold.dgate", o_dgate, 32'h7FFF_FFFF);
`else
      check("hold.dgate", o_dgate, 32'hFE00_0000);
`endif
      check("hold.dstate", o_d_state, 32'h00C0_0000);
    end

    // MUL1 negative overflow
    idle();
    sel_in1 = 2; sel_in2 = 3; t = 32'h8100_0000; h = 32'h0200_0000;
    tick();
    sel_in5 = 1;
    tick();
`ifdef DELTA_SAT_EN
    check("mul_ovf_neg", o_dgate, 32'h8000_0000);
`else
    check("mul_ovf_neg", o_dgate, 32'h0200_0000);
`endif

    // Load r_temp and r_x1 with nonzero values, then reset mid-cycle
    idle();
    sel_x1_1 = 1; ft = 32'h0080_0000;
    tick();
    sel_temp = 3;
    tick();
    rst = 1'b0;
    #1;
    check("async_rst.dgate", o_dgate, 32'h0);
    check("async_rst.dstate", o_d_state, 32'h0);
    idle();
    sel_in5 = 3;
    tick();
    check("rst_held.dgate", o_dgate, 32'h0);
    rst = 1'b1;
    sel_in5 = 1;
    tick();
    check("post_rst.r_x1", o_dgate, 32'h0);
    sel_in5 = 6;
    tick();
    check("post_rst.r_temp", o_dgate, 32'h0);
    check("post_rst.dstate", o_d_state, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
